// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues memory requests and fills the IF/ID register.
// Handles stall hold, bubble drain, aligned redirects and a sticky misaligned-redirect fault.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_IMemAddr,
   output logic        o_IMemReq,
   input  logic [31:0] i_IMemData,
   input  logic        i_IMemValid,
   input  logic        i_Stall,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectPC,
   output logic [31:0] o_Instr,
   output logic [31:0] o_PC,
   output logic        o_Valid,
   output logic [6:0]  o_OPCode,
   output logic        o_Fault
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        req;
   logic        accept;

   // Handshake: a fetch completes in any cycle where o_IMemReq and i_IMemValid are both high.
   assign req    = (state_q == RUN) && !i_Redirect && !(valid_q && i_Stall);
   assign accept = req && i_IMemValid;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         out_pc_q <= 32'h00000000;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         out_pc_q <= out_pc_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      out_pc_d = out_pc_q;
      valid_d  = valid_q;
      fault_d  = fault_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (i_Redirect) begin
               // Redirect wins over stall and over any data returned this cycle.
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               if (i_RedirectPC[1:0] != 2'b00) begin
                  state_d  = FAULT;
                  fault_d  = 1'b1;
                  out_pc_d = i_RedirectPC;
               end else begin
                  pc_d = i_RedirectPC;
               end
            end else if (accept) begin
               instr_d  = i_IMemData;
               out_pc_d = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_q + 32'd4;
            end else if (valid_q && !i_Stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end
         FAULT: state_d = FAULT;
         default: state_d = BOOT;
      endcase
   end

   assign o_IMemAddr = pc_q;
   assign o_IMemReq  = req;
   assign o_Instr    = instr_q;
   assign o_PC       = out_pc_q;
   assign o_Valid    = valid_q;
   assign o_OPCode   = instr_q[6:0];
   assign o_Fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle model of the fetch rules checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h00000000;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   logic        clk;
   logic        i_rst;
   logic [31:0] o_IMemAddr;
   logic        o_IMemReq;
   logic [31:0] i_IMemData;
   logic        i_IMemValid;
   logic        i_Stall;
   logic        i_Redirect;
   logic [31:0] i_RedirectPC;
   logic [31:0] o_Instr;
   logic [31:0] o_PC;
   logic        o_Valid;
   logic [6:0]  o_OPCode;
   logic        o_Fault;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .o_IMemAddr(o_IMemAddr), .o_IMemReq(o_IMemReq),
      .i_IMemData(i_IMemData), .i_IMemValid(i_IMemValid),
      .i_Stall(i_Stall), .i_Redirect(i_Redirect), .i_RedirectPC(i_RedirectPC),
      .o_Instr(o_Instr), .o_PC(o_PC), .o_Valid(o_Valid),
      .o_OPCode(o_OPCode), .o_Fault(o_Fault)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Instruction memory contents as seen by the bench
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h00000033;
         32'h4:   return 32'h00002003;
         32'h8:   return 32'h00002023;
         32'hC:   return 32'h00000063;
         default: return (a << 8) | 32'h00000037;
      endcase
   endfunction

   assign i_IMemData = mem_word(o_IMemAddr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0=boot, 1=running, 2=faulted
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_opc;
   logic        m_valid, m_fault, exp_req;

   always @(negedge clk) begin
      if (i_rst) begin
         m_mode = 0; m_pc = RESET_PC; m_instr = NOP_INSTR;
         m_opc = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
      end
      exp_req = (m_mode == 1) && !i_Redirect && !(m_valid && i_Stall);
      chk("model_addr",   o_IMemAddr, m_pc);
      chk("model_req",    {31'b0, o_IMemReq}, {31'b0, exp_req});
      chk("model_instr",  o_Instr, m_instr);
      chk("model_pc",     o_PC, m_opc);
      chk("model_valid",  {31'b0, o_Valid}, {31'b0, m_valid});
      chk("model_opcode", {25'b0, o_OPCode}, {25'b0, m_instr[6:0]});
      chk("model_fault",  {31'b0, o_Fault}, {31'b0, m_fault});
      // advance the model to the state expected after the coming rising edge
      if (!i_rst) begin
         if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (i_Redirect && i_RedirectPC[1:0] != 2'b00) begin
               m_mode = 2; m_fault = 1'b1; m_valid = 1'b0;
               m_instr = NOP_INSTR; m_opc = i_RedirectPC;
            end else if (i_Redirect) begin
               m_pc = i_RedirectPC; m_valid = 1'b0; m_instr = NOP_INSTR;
            end else if (exp_req && i_IMemValid) begin
               m_instr = mem_word(m_pc); m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end else if (m_valid && !i_Stall) begin
               m_valid = 1'b0; m_instr = NOP_INSTR;
            end
         end
      end
   end

   // Driver tasks
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      i_rst = 1'b1; i_IMemValid = 1'b1; i_Stall = 1'b0;
      i_Redirect = 1'b0; i_RedirectPC = 32'h0;
      nxt(); nxt();
      i_rst = 1'b0;
      smp();
      chk("lit_boot_req",   {31'b0, o_IMemReq}, 32'd0);
      chk("lit_boot_instr", o_Instr, 32'h00000013);
      chk("lit_boot_valid", {31'b0, o_Valid}, 32'd0);
      nxt(); smp();
      chk("lit_first_req",  {31'b0, o_IMemReq}, 32'd1);
      chk("lit_first_addr", o_IMemAddr, 32'h0);
      nxt(); smp();
      chk("lit_seq0_pc",  o_PC, 32'h0);
      chk("lit_seq0_op",  {25'b0, o_OPCode}, {25'b0, 7'b0110011});
      chk("lit_seq0_vld", {31'b0, o_Valid}, 32'd1);
      nxt(); smp();
      chk("lit_seq1_pc",  o_PC, 32'h4);
      chk("lit_seq1_op",  {25'b0, o_OPCode}, {25'b0, 7'b0000011});
      nxt(); smp();
      chk("lit_seq2_pc",  o_PC, 32'h8);
      chk("lit_seq2_op",  {25'b0, o_OPCode}, {25'b0, 7'b0100011});
      nxt();
      i_Redirect = 1'b1; i_RedirectPC = 32'h4;
      smp();
      chk("lit_seq3_pc",  o_PC, 32'hC);
      chk("lit_seq3_op",  {25'b0, o_OPCode}, {25'b0, 7'b1100011});
      chk("lit_redir_req", {31'b0, o_IMemReq}, 32'd0);
      nxt();
      i_Redirect = 1'b0;
      smp();
      chk("lit_redir4_addr", o_IMemAddr, 32'h4);
      // stall for three cycles on the load at PC 4
      nxt();
      i_Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("lit_stall_instr", o_Instr, 32'h00002003);
         chk("lit_stall_pc",    o_PC, 32'h4);
         chk("lit_stall_addr",  o_IMemAddr, 32'h8);
         chk("lit_stall_req",   {31'b0, o_IMemReq}, 32'd0);
         nxt();
      end
      i_Stall = 1'b0;
      smp();
      chk("lit_resume_req",  {31'b0, o_IMemReq}, 32'd1);
      chk("lit_resume_addr", o_IMemAddr, 32'h8);
      // memory not ready for two cycles
      nxt();
      i_IMemValid = 1'b0;
      smp();
      chk("lit_after_stall_pc", o_PC, 32'h8);
      nxt(); smp();
      chk("lit_drain_valid", {31'b0, o_Valid}, 32'd0);
      chk("lit_drain_instr", o_Instr, 32'h00000013);
      chk("lit_drain_op",    {25'b0, o_OPCode}, {25'b0, 7'b0010011});
      chk("lit_drain_addr",  o_IMemAddr, 32'hC);
      nxt();
      i_IMemValid = 1'b1;
      smp();
      nxt();
      // redirect to 0x100 while stalled with memory data available
      i_Redirect = 1'b1; i_RedirectPC = 32'h100; i_Stall = 1'b1;
      smp();
      chk("lit_pre_redir_pc", o_PC, 32'hC);
      nxt();
      i_Redirect = 1'b0; i_Stall = 1'b0;
      smp();
      chk("lit_r100_valid", {31'b0, o_Valid}, 32'd0);
      chk("lit_r100_addr",  o_IMemAddr, 32'h100);
      nxt();
      i_Redirect = 1'b1; i_RedirectPC = 32'h102;
      smp();
      chk("lit_r100_instr", o_Instr, 32'h00010037);
      chk("lit_r100_pc",    o_PC, 32'h100);
      nxt();
      i_Redirect = 1'b0;
      smp();
      chk("lit_fault",       {31'b0, o_Fault}, 32'd1);
      chk("lit_fault_pc",    o_PC, 32'h102);
      chk("lit_fault_addr",  o_IMemAddr, 32'h104);
      nxt();
      i_Redirect = 1'b1; i_RedirectPC = 32'h200;
      nxt();
      i_Redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("lit_fault_hold_req", {31'b0, o_IMemReq}, 32'd0);
         chk("lit_fault_hold_pc",  o_PC, 32'h102);
         nxt();
      end
      // reset pulse clears the fault immediately
      i_rst = 1'b1;
      #1;
      chk("lit_rst_fault", {31'b0, o_Fault}, 32'd0);
      chk("lit_rst_addr",  o_IMemAddr, 32'h0);
      chk("lit_rst_opc",   o_PC, 32'h0);
      nxt();
      i_rst = 1'b0;
      smp();
      chk("lit_reboot_req", {31'b0, o_IMemReq}, 32'd0);
      nxt(); smp();
      chk("lit_rerun_req", {31'b0, o_IMemReq}, 32'd1);
      nxt();
      i_Redirect = 1'b1; i_RedirectPC = 32'hFFFFFFFC;
      smp();
      chk("lit_refetch_instr", o_Instr, 32'h00000033);
      nxt();
      i_Redirect = 1'b0;
      smp();
      chk("lit_top_addr", o_IMemAddr, 32'hFFFFFFFC);
      nxt();
      i_Stall = 1'b1;
      smp();
      chk("lit_wrap_addr", o_IMemAddr, 32'h0);
      chk("lit_wrap_pc",   o_PC, 32'hFFFFFFFC);
      // reset while stalled
      nxt();
      i_rst = 1'b1;
      #1;
      chk("lit_rst_stall_valid", {31'b0, o_Valid}, 32'd0);
      chk("lit_rst_stall_instr", o_Instr, 32'h00000013);
      nxt();
      i_rst = 1'b0; i_Stall = 1'b0;
      nxt(); smp();
      chk("lit_rst_stall_req", {31'b0, o_IMemReq}, 32'd1);
      for (int i = 0; i < 4; i++) nxt();
      smp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
